hsid_x_obi_wr: RTL and testbench
================================

Name: hsid_x_obi_wr

Overview:
OBI manager that streams result words into consecutive memory locations. It is the write-direction counterpart of the OBI block reader in the hsid_x datapath.
- Accepts words on a valid/ready input stream and buffers them in a small FIFO.
- Issues one OBI write per word, starting at initial_addr and incrementing by WORD_WIDTH/8.
- Signals done once every write has been granted and acknowledged by rvalid.

Parameters:
WORD_WIDTH, HSID_WORD_WIDTH, data/address word width in bits
MEM_ACCESS_WIDTH, HSID_MEM_ACCESS_WIDTH, width of the word-count limit
FIFO_DEPTH, HSID_OBI_WR_FIFO_DEPTH (4), input buffer depth in words, power of two, >=2

Ports:
clk  in  1  clock; the block has one clock
rst  in  1  reset, synchronous, active-high
obi_req  out  hsid_x_obi_inf_pkg::obi_req_t  OBI request (req, addr, we, be, wdata)
obi_rsp  in  hsid_x_obi_inf_pkg::obi_resp_t  OBI response (gnt, rvalid, rdata ignored)
initial_addr  in  WORD_WIDTH  byte address of the first write; sampled in INIT
limit  in  MEM_ACCESS_WIDTH  number of words to write; sampled in INIT; 0 is treated as 1
data_in_valid  in  1  input word valid
data_in  in  WORD_WIDTH  input word
data_in_ready  out  1  input word accepted when valid && ready
start  in  1  begin a transfer (honoured in IDLE only)
clear  in  1  abort and flush
idle  out  1  high in IDLE
ready  out  1  high in INIT and WRITING
done  out  1  one-cycle pulse in DONE

Behaviour:
- States: IDLE, INIT, WRITING, DONE, CLEAR.
  - IDLE -> INIT when start && !clear.
  - INIT -> CLEAR if clear, else WRITING.
  - WRITING -> CLEAR if clear; else -> DONE when responses == current_limit; else stays.
  - DONE -> IDLE. CLEAR -> IDLE.
- Reset (rst high at a clk edge, in any state):
  - State -> IDLE; FIFO emptied; all counters 0; current_limit = 1.
  - obi_req all fields 0; data_in_ready = 0; idle = 1; ready = 0; done = 0.
- INIT:
  - addr_q <= initial_addr; current_limit <= (limit==0) ? 1 : limit.
  - accepted, grants, responses <= 0; FIFO emptied.
- Input side:
  - data_in_ready = (state==WRITING) && !fifo_full && (accepted < current_limit).
  - A handshake pushes data_in and increments accepted.
  - Words offered outside WRITING, or beyond the limit, are not accepted.
- OBI request:
  - obi_req.req = (state==WRITING) && !fifo_empty && (grants < current_limit).
  - we = 1; be = all ones; addr = addr_q; wdata = FIFO head.
  - No combinational path from obi_rsp to obi_req.
  - While req && !gnt, addr and wdata stay stable, because the FIFO pops only on gnt.
- On req && gnt: pop the FIFO; addr_q += WORD_WIDTH/8, wrapping modulo 2^WORD_WIDTH; grants++.
- On rvalid in WRITING with responses < current_limit: responses++. rvalid in any other state, or in excess, is ignored.
- Latency:
  - A word accepted at edge N is visible at the FIFO head after edge N.
  - req can be high in cycle N+1; a same-cycle gnt completes the address phase in one cycle.
- Full throughput: with continuous valid, gnt and rvalid, one word per cycle after the first.
- Simultaneous push and pop (FIFO not full) in the same cycle: both happen; occupancy unchanged.
- Push and pop on an empty FIFO: no bypass; req waits one cycle.
- Counter widths: accepted, grants and responses are MEM_ACCESS_WIDTH+1 bits.
- clear in INIT or WRITING:
  - Next state is CLEAR; the FIFO flushes and req is 0 from that next cycle on.
  - An un-granted request is abandoned (documented limitation).
  - Outstanding responses are ignored.
- clear in IDLE blocks start. clear in DONE or CLEAR has no effect.
- start while busy: ignored.

Decomposition:
- hsid_pkg: HSID_OBI_WR_FIFO_DEPTH constant; hsid_x_obi_wr_state_t enum (logic [2:0]).
- OBI types from hsid_x_obi_inf_pkg.
- One sub-module: hsid_x_sync_fifo, a parameterized WIDTH/DEPTH synchronous FIFO.
  - Ports: push, pop, wdata, rdata (head), full, empty, flush.
  - Synchronous active-high reset.

Test Plan:
- Basic write: initial_addr=0x1000, limit=4, data 0xA,0xB,0xC,0xD streamed back-to-back; gnt tied 1; rvalid one cycle after each gnt -> writes to 0x1000/1004/1008/100C with matching wdata, we=1, be=4'hF; done pulses once; then idle=1.
- Backpressure: limit=8, FIFO_DEPTH=4, gnt held 0 for 10 cycles -> data_in_ready drops after 4 words; req, addr=initial_addr and wdata stay stable; after gnt releases, all 8 words are written in order.
- limit=0 -> exactly one write to initial_addr, then done.
- Address wrap: initial_addr=0xFFFFFFFC, limit=2 -> second write at 0x00000000.
- Mid-transfer clear: limit=6, assert clear after 2 grants -> CLEAR then IDLE; req=0 from the cycle after clear; late rvalid ignored; no done; a following start with limit=1 writes cleanly.
- Reset mid-operation: rst during WRITING -> next cycle all obi_req fields 0, data_in_ready=0, idle=1; FIFO empty at restart.

Source files
------------

// File: rtl/hsid_pkg.sv
// hsid_pkg: shared constants and state encoding for the hsid_x datapath
package hsid_pkg;
  localparam int HSID_WORD_WIDTH = 32;
  localparam int HSID_MEM_ACCESS_WIDTH = 16;
  localparam int HSID_OBI_WR_FIFO_DEPTH = 4;
  typedef enum logic [2:0] {
    OBI_WR_IDLE,
    OBI_WR_INIT,
    OBI_WR_WRITING,
    OBI_WR_DONE,
    OBI_WR_CLEAR
  } hsid_x_obi_wr_state_t;
endpackage

// File: rtl/hsid_x_obi_inf_pkg.sv
// hsid_x_obi_inf_pkg: OBI request/response bundles
package hsid_x_obi_inf_pkg;
  typedef struct packed {
    logic req;
    logic we;
    logic [hsid_pkg::HSID_WORD_WIDTH/8-1:0] be;
    logic [hsid_pkg::HSID_WORD_WIDTH-1:0] addr;
    logic [hsid_pkg::HSID_WORD_WIDTH-1:0] wdata;
  } obi_req_t;
  typedef struct packed {
    logic gnt;
    logic rvalid;
    logic [hsid_pkg::HSID_WORD_WIDTH-1:0] rdata;
  } obi_resp_t;
endpackage

// File: rtl/hsid_x_sync_fifo.sv
// hsid_x_sync_fifo: power-of-two synchronous FIFO with flush, head visible on rdata
module hsid_x_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign rdata = mem[rp[AW-1:0]];
  always_ff @(posedge clk) begin
    if (push && !full) mem[wp[AW-1:0]] <= wdata;
  end
  // flush outranks a same-cycle push so nothing survives an abort
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + 1'b1;
      if (pop && !empty) rp <= rp + 1'b1;
    end
  end
endmodule

// File: rtl/hsid_x_obi_wr.sv
// hsid_x_obi_wr: OBI manager writing a buffered word stream to consecutive addresses
module hsid_x_obi_wr
  import hsid_pkg::*;
  import hsid_x_obi_inf_pkg::*;
#(
  parameter int WORD_WIDTH = HSID_WORD_WIDTH,
  parameter int MEM_ACCESS_WIDTH = HSID_MEM_ACCESS_WIDTH,
  parameter int FIFO_DEPTH = HSID_OBI_WR_FIFO_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst,
  output obi_req_t                    obi_req,
  input  obi_resp_t                   obi_rsp,
  input  logic [WORD_WIDTH-1:0]       initial_addr,
  input  logic [MEM_ACCESS_WIDTH-1:0] limit,
  input  logic                        data_in_valid,
  input  logic [WORD_WIDTH-1:0]       data_in,
  output logic                        data_in_ready,
  input  logic                        start,
  input  logic                        clear,
  output logic                        idle,
  output logic                        ready,
  output logic                        done
);
  localparam int CW = MEM_ACCESS_WIDTH + 1;
  hsid_x_obi_wr_state_t state_q, state_d;
  logic [WORD_WIDTH-1:0] addr_q, head;
  logic [CW-1:0] cur_limit, accepted, grants, responses;
  logic full, empty, flush, push, pop, req, writing, unused_rdata;
  assign unused_rdata = ^obi_rsp.rdata;
  assign writing = state_q == OBI_WR_WRITING;
  assign ready = state_q == OBI_WR_INIT || writing;
  assign idle = state_q == OBI_WR_IDLE;
  assign done = state_q == OBI_WR_DONE;
  assign flush = state_q == OBI_WR_INIT || state_q == OBI_WR_CLEAR || (ready && clear);
  assign data_in_ready = writing && !full && accepted < cur_limit;
  assign push = data_in_valid && data_in_ready;
  assign req = writing && !empty && grants < cur_limit;
  assign pop = req && obi_rsp.gnt;
  hsid_x_sync_fifo #(.WIDTH(WORD_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .flush(flush), .push(push), .pop(pop),
    .wdata(data_in), .rdata(head), .full(full), .empty(empty)
  );
  // request fields are zeroed while idle so the bus is quiet outside a write
  always_comb begin
    obi_req = '0;
    obi_req.req = req;
    obi_req.we = req;
    obi_req.be = req ? '1 : '0;
    obi_req.addr = req ? addr_q : '0;
    obi_req.wdata = req ? head : '0;
    state_d = state_q;
    case (state_q)
      OBI_WR_IDLE:    state_d = (start && !clear) ? OBI_WR_INIT : OBI_WR_IDLE;
      OBI_WR_INIT:    state_d = clear ? OBI_WR_CLEAR : OBI_WR_WRITING;
      OBI_WR_WRITING: state_d = clear ? OBI_WR_CLEAR : (responses == cur_limit ? OBI_WR_DONE : OBI_WR_WRITING);
      default:        state_d = OBI_WR_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OBI_WR_IDLE;
      addr_q <= '0;
      cur_limit <= CW'(1);
      accepted <= '0;
      grants <= '0;
      responses <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == OBI_WR_INIT) begin
        addr_q <= initial_addr;
        cur_limit <= (limit == '0) ? CW'(1) : CW'(limit);
        accepted <= '0;
        grants <= '0;
        responses <= '0;
      end else begin
        if (push) accepted <= accepted + CW'(1);
        if (pop) begin
          addr_q <= addr_q + WORD_WIDTH'(WORD_WIDTH / 8);
          grants <= grants + CW'(1);
        end
        if (writing && obi_rsp.rvalid && responses < cur_limit) responses <= responses + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_hsid_x_obi_wr.sv
// tb_hsid_x_obi_wr: directed scoreboard bench for the OBI stream writer
module tb_hsid_x_obi_wr;
  import hsid_pkg::*;
  import hsid_x_obi_inf_pkg::*;
  logic clk = 0, rst = 1;
  logic [31:0] initial_addr = '0, data_in = '0;
  logic [15:0] limit = '0;
  logic data_in_valid = 0, start = 0, clear = 0;
  logic data_in_ready, idle, ready, done;
  logic gnt_en = 1, rv = 0;
  obi_req_t obi_req;
  obi_resp_t obi_rsp;
  int tests = 0, fails = 0, wr_cnt = 0, done_cnt = 0, acc_cnt = 0;
  bit stop_feed = 0;
  logic [63:0] sb [$];

  always #5 clk = ~clk;

  always_comb begin
    obi_rsp = '0;
    obi_rsp.gnt = gnt_en;
    obi_rsp.rvalid = rv;
  end

  always @(posedge clk) rv <= obi_req.req && obi_rsp.gnt;

  hsid_x_obi_wr dut (
    .clk(clk), .rst(rst), .obi_req(obi_req), .obi_rsp(obi_rsp),
    .initial_addr(initial_addr), .limit(limit),
    .data_in_valid(data_in_valid), .data_in(data_in), .data_in_ready(data_in_ready),
    .start(start), .clear(clear), .idle(idle), .ready(ready), .done(done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    tests++;
    fails++;
    $error("FAIL %s: observed timeout expected event", tag);
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (obi_req.req === 1'b1 && obi_rsp.gnt === 1'b1) begin
      logic [63:0] e;
      wr_cnt++;
      if (sb.size() == 0) timeout("unexpected_write");
      else begin
        e = sb.pop_front();
        chk("wr_addr", obi_req.addr, e[63:32]);
        chk("wr_data", obi_req.wdata, e[31:0]);
        chk("wr_we", obi_req.we, 1);
        chk("wr_be", obi_req.be, 4'hF);
      end
    end
  end

  task automatic start_xfer(input logic [31:0] a, input logic [15:0] l);
    @(posedge clk);
    #1;
    initial_addr = a;
    limit = l;
    start = 1;
    @(posedge clk);
    #1 start = 0;
  endtask

  task automatic feed(input logic [31:0] a, input int n, input logic [31:0] d0);
    for (int k = 0; k < n; k++) begin
      bit got;
      int t;
      got = 0;
      data_in = d0 + 32'(k);
      data_in_valid = 1;
      for (t = 0; t < 200 && !got && !stop_feed; t++) begin
        @(negedge clk);
        got = data_in_ready;
      end
      if (!got) begin
        if (!stop_feed) timeout("feed");
        break;
      end
      sb.push_back({a + 32'(4 * k), d0 + 32'(k)});
      acc_cnt++;
      @(posedge clk);
      #1;
    end
    data_in_valid = 0;
  endtask

  task automatic wait_idle(input string tag);
    int t;
    for (t = 0; t < 300; t++) begin
      @(negedge clk);
      if (idle === 1'b1) break;
    end
    if (t == 300) timeout(tag);
  endtask

  task automatic run_xfer(input string tag, input logic [31:0] a, input logic [15:0] l, input int n, input logic [31:0] d0);
    int d, w;
    d = done_cnt;
    w = wr_cnt;
    start_xfer(a, l);
    feed(a, n, d0);
    wait_idle({tag, "_idle"});
    @(negedge clk);
    chk({tag, "_done_once"}, done_cnt - d, 1);
    chk({tag, "_writes"}, wr_cnt - w, n);
    chk({tag, "_sb_empty"}, sb.size(), 0);
    chk({tag, "_idle"}, idle, 1);
  endtask

  initial begin
    int w, d, a0, t2;
    @(posedge clk);
    @(negedge clk);
    chk("rst_req", obi_req, 0);
    chk("rst_in_ready", data_in_ready, 0);
    chk("rst_idle", idle, 1);
    chk("rst_ready", ready, 0);
    chk("rst_done", done, 0);
    @(posedge clk);
    #1 rst = 0;

    run_xfer("basic", 32'h1000, 4, 4, 32'hA);

    gnt_en = 0;
    a0 = acc_cnt;
    w = wr_cnt;
    start_xfer(32'h3000, 8);
    fork
      feed(32'h3000, 8, 32'h100);
      begin
        repeat (12) @(negedge clk);
        chk("bp_in_ready_low", data_in_ready, 0);
        chk("bp_accepted", acc_cnt - a0, 4);
        chk("bp_req", obi_req.req, 1);
        chk("bp_addr", obi_req.addr, 32'h3000);
        chk("bp_wdata", obi_req.wdata, 32'h100);
        repeat (3) @(negedge clk);
        chk("bp_addr_hold", obi_req.addr, 32'h3000);
        chk("bp_wdata_hold", obi_req.wdata, 32'h100);
        gnt_en = 1;
      end
    join
    wait_idle("bp_idle");
    chk("bp_writes", wr_cnt - w, 8);
    chk("bp_sb_empty", sb.size(), 0);

    run_xfer("lim0", 32'h4000, 0, 1, 32'h55);
    data_in_valid = 1;
    data_in = 32'hDEAD;
    @(negedge clk);
    chk("idle_no_accept", data_in_ready, 0);
    data_in_valid = 0;

    run_xfer("wrap", 32'hFFFF_FFFC, 2, 2, 32'h77);

    w = wr_cnt;
    d = done_cnt;
    stop_feed = 0;
    start_xfer(32'h5000, 6);
    fork
      feed(32'h5000, 6, 32'h200);
      begin
        for (t2 = 0; t2 < 100; t2++) begin
          @(negedge clk);
          if (wr_cnt - w >= 2) break;
        end
        if (t2 == 100) timeout("clr_grants");
        clear = 1;
        @(posedge clk);
        #1 clear = 0;
        stop_feed = 1;
        @(negedge clk);
        chk("clr_req_low", obi_req.req, 0);
        chk("clr_ready_low", ready, 0);
        chk("clr_not_idle", idle, 0);
        @(negedge clk);
        chk("clr_idle", idle, 1);
        chk("clr_req_low2", obi_req.req, 0);
      end
    join
    stop_feed = 0;
    sb.delete();
    repeat (4) @(negedge clk);
    chk("clr_no_done", done_cnt - d, 0);
    run_xfer("after_clr", 32'h6000, 1, 1, 32'h99);

    gnt_en = 0;
    start_xfer(32'h7000, 4);
    feed(32'h7000, 2, 32'h300);
    @(negedge clk);
    chk("mid_req", obi_req.req, 1);
    @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("mrst_req", obi_req, 0);
    chk("mrst_in_ready", data_in_ready, 0);
    chk("mrst_idle", idle, 1);
    chk("mrst_ready", ready, 0);
    sb.delete();
    gnt_en = 1;
    run_xfer("after_rst", 32'h8000, 1, 1, 32'h400);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
